plab4_net_router_output_sched: RTL and testbench
================================================

# plab4_net_router_output_sched

Output-port scheduler for the secure mesh router. It shares one output port and its crossbar column among the three router inputs, and enforces fixed temporal partitioning between two security domains. It also holds wormhole packet locks per domain so that multi-flit packets are never interleaved. The domain slot schedule depends only on the cycle count, never on traffic, so one domain cannot modulate the timing seen by the other.

## Interface
- p_slot_len, 16: cycles per domain slot, including the dead cycles; must be ≥ p_dead_cycles+1.
- p_dead_cycles, 2: grant-free cycles at the start of every slot, used for pipeline drain.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; state clears while reset=0.
- reqs  in  3  per-input request; the input's head-of-queue flit is valid.
- req_sd  in  3  per-input domain tag of that flit (0 or 1).
- req_tail  in  3  per-input flag: that flit is the packet's tail. A single-flit packet has its head flit marked as tail.
- out_rdy  in  1  downstream can accept a flit this cycle.
- grants  out  3  one-hot grant, or all zero.
- out_val  out  1  = |grants.
- xbar_sel  out  2  grants 001→0, 010→1, any other value→2.
- cur_sd  out  1  domain that owns the current slot.

## Operation
- Slot timer `cnt` counts 0…p_slot_len-1 and wraps.
  - When cnt == p_slot_len-1, the next edge sets cnt=0 and toggles cur_sd.
  - The timer runs unconditionally, with no dependence on reqs or out_rdy.
- Phase:
  - DEAD while cnt < p_dead_cycles.
  - ACTIVE otherwise.
  - In DEAD, grants=0.
- Eligibility of input i in ACTIVE:
  - Requires reqs[i] & out_rdy & (req_sd[i]==cur_sd).
  - If lock_vld[cur_sd] is set, input lock_id[cur_sd] is the only input that may be eligible.
  - If the locked input is not requesting, grants=0. Other inputs are never granted mid-packet.
- Arbitration: round-robin among eligible inputs, starting at prio[cur_sd] and searching upward modulo 3.
- Transfer: occurs in a cycle with out_val & out_rdy; input w is the granted input.
  - Non-tail flit: lock_vld[cur_sd]←1, lock_id[cur_sd]←w.
  - Tail flit: lock_vld[cur_sd]←0, prio[cur_sd]←(w+1) mod 3.
- Per-domain state: lock_vld, lock_id and prio are kept separately for domain 0 and domain 1.
  - The state of the domain not in its slot is frozen.
  - A packet still locked at slot end is suspended. It resumes, still locked, after the DEAD phase of that domain's next slot.
- Width rules:
  - cnt width is clog2(p_slot_len); it wraps explicitly, not by overflow.
  - lock_id and prio are 2 bits and take values 0–2 only.
- Reset values (while reset=0): cnt=0, cur_sd=0, lock_vld[0]=lock_vld[1]=0, prio[0]=prio[1]=0.
  - Outputs: grants=000, out_val=0, xbar_sel=2.

## Timing
- grants, out_val and xbar_sel are combinational from reqs, req_sd, req_tail, out_rdy and registered state, with zero-cycle latency.
- out_rdy=0 forces grants=0. Nothing is transferred and no state changes except the timer.
- Slot boundary:
  - On the last ACTIVE cycle, grants are issued normally and a transfer completes.
  - The next cycle is DEAD of the other domain.
- A tail transfer and the slot wrap in the same cycle: the lock clears and prio updates for the old domain, and cur_sd toggles. Both take effect at that edge.
- Reset asserted mid-packet clears all locks. Upstream is expected to flush, and the scheduler accepts any new head afterwards.
- Reset deassertion is taken synchronously at the clk edge. The first cycle after reset is cnt=0, cur_sd=0, DEAD.
- Domain-0 traffic has no effect on domain-1 slot timing. Each domain's grant opportunity begins exactly p_dead_cycles after its slot starts.

## Test plan
- Reset and idle, with p_slot_len=16 and p_dead_cycles=2:
  - After reset, grants=000, xbar_sel=2, cur_sd=0.
  - cur_sd toggles at cycles 16, 32 and 48, with no requests present.
- Dead phase, with input 1 requesting domain 0 continuously from reset, single-flit packets and out_rdy=1:
  - Grants are 010 first at cycle 2, and every cycle through 15.
  - grants=000 for cycles 16–33. The first grant in the next domain-0 slot is at cycle 34.
- Round-robin within a domain, with all three inputs requesting domain 0 with single-flit packets:
  - grants sequence 001, 010, 100, 001…
  - xbar_sel sequence 0, 1, 2, 0…
- Domain filtering, with input 0 as domain 1 and input 2 as domain 0, both requesting:
  - Slot 0 grants only 100. Slot 1 grants only 001.
  - Input 0 is never granted while cur_sd=0.
- Wormhole lock and suspension:
  - Stimulus:
    - Input 0 sends a 20-flit domain-0 packet, starting at cycle 2.
    - Input 1 requests domain 0 throughout.
  - Required response:
    - grants=001 for cycles 2–15. Input 1 is not granted.
    - grants=000 for cycles 16–33.
    - Input 0 resumes at cycle 34 and sends its tail at cycle 39. Input 1 is granted at cycle 40.
- out_rdy stall and mid-packet reset:
  - out_rdy=0 during a locked packet gives grants=000 and the lock is held.
  - Asserting reset (reset=0) mid-packet gives an immediate grants=000, and lock_vld is cleared after release.

Source files
------------

// File: rtl/plab4_net_router_output_sched_if.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_sched_if
// Handshake bundle between the three router inputs and one output-port
// scheduler.
//   reqs     : per-input head-flit valid
//   req_sd   : per-input security-domain tag of the head flit
//   req_tail : per-input "head flit is the packet tail"
//   out_rdy  : downstream can accept a flit this cycle
//   grants   : one-hot grant (or zero) back to the inputs
//   out_val  : a flit is driven onto the output this cycle
//   xbar_sel : crossbar column select (0,1,2)
//   cur_sd   : security domain owning the current slot
// The scheduler uses the slave modport; the input side uses master.
// ----------------------------------------------------------------------------
interface plab4_net_router_output_sched_if;
    logic [2:0] reqs;
    logic [2:0] req_sd;
    logic [2:0] req_tail;
    logic       out_rdy;
    logic [2:0] grants;
    logic       out_val;
    logic [1:0] xbar_sel;
    logic       cur_sd;

    modport master (
        output reqs, req_sd, req_tail, out_rdy,
        input  grants, out_val, xbar_sel, cur_sd
    );

    modport slave (
        input  reqs, req_sd, req_tail, out_rdy,
        output grants, out_val, xbar_sel, cur_sd
    );
endinterface

// File: rtl/plab4_net_router_output_sched.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_sched
// Output-port scheduler for the secure mesh router. Time is split into fixed
// slots that alternate between security domain 0 and 1; each slot begins with
// p_dead_cycles grant-free cycles. Within the active part of a slot the three
// inputs of the owning domain are arbitrated round-robin, and wormhole locks
// keep multi-flit packets contiguous. Lock and priority state is kept per
// domain and only the owning domain's copy ever changes.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : scheduler side of plab4_net_router_output_sched_if
// ----------------------------------------------------------------------------
module plab4_net_router_output_sched #(
    parameter int p_slot_len    = 16,
    parameter int p_dead_cycles = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    plab4_net_router_output_sched_if.slave       bus
);

    localparam int CW = (p_slot_len > 1) ? $clog2(p_slot_len) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(p_slot_len - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(p_dead_cycles);

    // Round-robin pick: first set bit of elig searching upward from start, mod 3.
    function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] start);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, start} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end else begin
                idx = idx;
            end
            if (!found && elig[idx[1:0]]) begin
                pick[idx[1:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            cur_sd_q,   cur_sd_d;
    logic [1:0]      lock_vld_q, lock_vld_d;
    logic [1:0][1:0] lock_id_q,  lock_id_d;
    logic [1:0][1:0] prio_q,     prio_d;

    logic            dead_s;
    logic [2:0]      elig_s;
    logic [2:0]      grants_s;
    logic [1:0]      sel_s;
    logic            tail_s;
    logic            xfer_s;

    // Eligibility, arbitration and crossbar select (zero-latency outputs).
    always_comb begin
        dead_s = (cnt_q < CNT_DEAD);
        elig_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            // A held lock masks every input except the lock owner.
            elig_s[i] = reqs_ok(i) & (~lock_vld_q[cur_sd_q] | (lock_id_q[cur_sd_q] == 2'(i)));
        end
        // Gating on reset makes grants drop the instant reset asserts.
        if (dead_s || !reset) begin
            grants_s = 3'b000;
        end else begin
            grants_s = rr_pick(elig_s, prio_q[cur_sd_q]);
        end
        case (grants_s)
            3'b001:  begin sel_s = 2'd0; tail_s = bus.req_tail[0]; end
            3'b010:  begin sel_s = 2'd1; tail_s = bus.req_tail[1]; end
            3'b100:  begin sel_s = 2'd2; tail_s = bus.req_tail[2]; end
            default: begin sel_s = 2'd2; tail_s = 1'b0;            end
        endcase
        xfer_s = (|grants_s) & bus.out_rdy;
    end

    function automatic logic reqs_ok(input int i);
        return bus.reqs[i] & bus.out_rdy & (bus.req_sd[i] == cur_sd_q);
    endfunction

    assign bus.grants   = grants_s;
    assign bus.out_val  = |grants_s;
    assign bus.xbar_sel = sel_s;
    assign bus.cur_sd   = cur_sd_q;

    // Next-state: free-running slot timer plus owning domain's lock/priority.
    always_comb begin
        cnt_d      = cnt_q;
        cur_sd_d   = cur_sd_q;
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        prio_d     = prio_q;

        // Timer depends on nothing but itself so slot timing leaks no traffic.
        if (cnt_q == CNT_LAST) begin
            cnt_d    = {CW{1'b0}};
            cur_sd_d = ~cur_sd_q;
        end else begin
            cnt_d    = cnt_q + CW'(1);
            cur_sd_d = cur_sd_q;
        end

        if (xfer_s) begin
            if (tail_s) begin
                lock_vld_d[cur_sd_q] = 1'b0;
                prio_d[cur_sd_q]     = (sel_s == 2'd2) ? 2'd0 : (sel_s + 2'd1);
            end else begin
                lock_vld_d[cur_sd_q] = 1'b1;
                lock_id_d[cur_sd_q]  = sel_s;
            end
        end else begin
            lock_vld_d = lock_vld_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= {CW{1'b0}};
            cur_sd_q   <= 1'b0;
            lock_vld_q <= 2'b00;
            lock_id_q  <= {2'd0, 2'd0};
            prio_q     <= {2'd0, 2'd0};
        end else begin
            cnt_q      <= cnt_d;
            cur_sd_q   <= cur_sd_d;
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            prio_q     <= prio_d;
        end
    end

endmodule

// File: tb/tb_plab4_net_router_output_sched.sv
// ----------------------------------------------------------------------------
// tb_plab4_net_router_output_sched
// Directed bench for the output-port scheduler (slot 16, dead 2). Cycle 0 is
// the first cycle after reset release; inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_plab4_net_router_output_sched;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   err_cnt;
    int   cyc;

    plab4_net_router_output_sched_if bus_if ();

    plab4_net_router_output_sched #(
        .p_slot_len    (16),
        .p_dead_cycles (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [2:0] r, input logic [2:0] sd, input logic [2:0] tl, input logic rdy);
        bus_if.reqs     = r;
        bus_if.req_sd   = sd;
        bus_if.req_tail = tl;
        bus_if.out_rdy  = rdy;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        apply(3'b111, 3'b000, 3'b111, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b000) begin err_cnt++; $display("FAIL reset_grants got=%b exp=000", bus_if.grants); end
        vec_cnt++;
        if (bus_if.xbar_sel !== 2'd2) begin err_cnt++; $display("FAIL reset_xbar got=%0d exp=2", bus_if.xbar_sel); end
        vec_cnt++;
        if (bus_if.cur_sd !== 1'b0) begin err_cnt++; $display("FAIL reset_cursd got=%b exp=0", bus_if.cur_sd); end
        vec_cnt++;
        if (bus_if.out_val !== 1'b0) begin err_cnt++; $display("FAIL reset_outval got=%b exp=0", bus_if.out_val); end
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b000) begin err_cnt++; $display("FAIL first_cycle_dead got=%b exp=000", bus_if.grants); end
    endtask

    task automatic test_idle();
        logic exp_sd;
        apply(3'b000, 3'b000, 3'b000, 1'b1);
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c != 0) next_cycle();
            #1;
            exp_sd = ((c / 16) % 2) == 1;
            vec_cnt++;
            if (bus_if.cur_sd !== exp_sd) begin err_cnt++; $display("FAIL idle_cursd cyc=%0d got=%b exp=%b", cyc, bus_if.cur_sd, exp_sd); end
        end
    endtask

    task automatic test_dead();
        logic [2:0] exp_g;
        apply(3'b010, 3'b000, 3'b111, 1'b1);
        do_reset();
        for (int c = 0; c < 41; c++) begin
            if (c != 0) next_cycle();
            #1;
            exp_g = ((c % 32) >= 2 && (c % 32) < 16) ? 3'b010 : 3'b000;
            vec_cnt++;
            if (bus_if.grants !== exp_g) begin err_cnt++; $display("FAIL dead_grants cyc=%0d got=%b exp=%b", cyc, bus_if.grants, exp_g); end
        end
    endtask

    task automatic test_round_robin();
        int         k;
        logic [2:0] exp_g;
        logic [1:0] exp_sel;
        k = 0;
        apply(3'b111, 3'b000, 3'b111, 1'b1);
        do_reset();
        for (int c = 0; c < 37; c++) begin
            if (c != 0) next_cycle();
            #1;
            if ((c % 32) >= 2 && (c % 32) < 16) begin
                exp_g   = 3'b001 << (k % 3);
                exp_sel = 2'(k % 3);
                k++;
            end else begin
                exp_g   = 3'b000;
                exp_sel = 2'd2;
            end
            vec_cnt++;
            if (bus_if.grants !== exp_g) begin err_cnt++; $display("FAIL rr_grants cyc=%0d got=%b exp=%b", cyc, bus_if.grants, exp_g); end
            vec_cnt++;
            if (bus_if.xbar_sel !== exp_sel) begin err_cnt++; $display("FAIL rr_xbar cyc=%0d got=%0d exp=%0d", cyc, bus_if.xbar_sel, exp_sel); end
        end
    endtask

    task automatic test_domain_filter();
        logic [2:0] exp_g;
        apply(3'b101, 3'b001, 3'b111, 1'b1);
        do_reset();
        for (int c = 0; c < 64; c++) begin
            if (c != 0) next_cycle();
            #1;
            if ((c % 16) < 2) exp_g = 3'b000;
            else if (((c / 16) % 2) == 0) exp_g = 3'b100;
            else exp_g = 3'b001;
            vec_cnt++;
            if (bus_if.grants !== exp_g) begin err_cnt++; $display("FAIL filter_grants cyc=%0d got=%b exp=%b", cyc, bus_if.grants, exp_g); end
        end
    endtask

    task automatic test_wormhole();
        int         sent0;
        logic [2:0] exp_g;
        sent0 = 0;
        apply(3'b011, 3'b000, 3'b010, 1'b1);
        do_reset();
        for (int c = 0; c < 41; c++) begin
            if (c != 0) next_cycle();
            // Input 0 holds a 20-flit packet, offered from cycle 2 onward.
            bus_if.reqs[0]     = (c >= 2) && (sent0 < 20);
            bus_if.req_tail[0] = (sent0 == 19);
            #1;
            if ((c >= 2 && c <= 15) || (c >= 34 && c <= 39)) exp_g = 3'b001;
            else if (c == 40) exp_g = 3'b010;
            else exp_g = 3'b000;
            vec_cnt++;
            if (bus_if.grants !== exp_g) begin err_cnt++; $display("FAIL worm_grants cyc=%0d got=%b exp=%b", cyc, bus_if.grants, exp_g); end
            if (exp_g == 3'b001) sent0++;
        end
    endtask

    task automatic test_stall_reset();
        apply(3'b011, 3'b000, 3'b010, 1'b1);
        do_reset();
        next_cycle();
        next_cycle();
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b001) begin err_cnt++; $display("FAIL stall_head got=%b exp=001", bus_if.grants); end
        next_cycle();
        bus_if.out_rdy = 1'b0;
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b000) begin err_cnt++; $display("FAIL stall_rdy0 got=%b exp=000", bus_if.grants); end
        next_cycle();
        apply(3'b010, 3'b000, 3'b010, 1'b1);
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b000) begin err_cnt++; $display("FAIL stall_lock_held got=%b exp=000", bus_if.grants); end
        next_cycle();
        apply(3'b011, 3'b000, 3'b010, 1'b1);
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b001) begin err_cnt++; $display("FAIL stall_resume got=%b exp=001", bus_if.grants); end
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b000) begin err_cnt++; $display("FAIL midpkt_reset_grants got=%b exp=000", bus_if.grants); end
        vec_cnt++;
        if (bus_if.xbar_sel !== 2'd2) begin err_cnt++; $display("FAIL midpkt_reset_xbar got=%0d exp=2", bus_if.xbar_sel); end
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        apply(3'b010, 3'b000, 3'b010, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        vec_cnt++;
        if (bus_if.grants !== 3'b010) begin err_cnt++; $display("FAIL post_reset_unlocked got=%b exp=010", bus_if.grants); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc     = 0;
        reset   = 1'b0;
        apply(3'b000, 3'b000, 3'b000, 1'b0);
        test_reset();
        test_idle();
        test_dead();
        test_round_robin();
        test_domain_filter();
        test_wormhole();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
